// File: rtl/model_bank_scheduler.sv
// ============================================================================
// Module   : model_bank_scheduler
// Brief    : Ping-pong bank sequencer for the Stage 3 datapath (load / eval /
//            unload+FIRX). Optional MODEL_SCHED_STATS_EN adds oBlockCount.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module model_bank_scheduler #(
    parameter int BLOCK_LEN = 4096,
    parameter int MAX_ORDER = 12,
    parameter int CNT_W     = 12
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iLoadDone,
    input  logic        iValid,
    input  logic        iFbDone,
    input  logic [3:0]  iBestM,
    input  logic        iDsDone,
    input  logic        iFirDone,
    output logic        oLoadSel,
    output logic        oEvalSel,
    output logic        oReady,
    output logic [1:0]  oFbReset,
    output logic [1:0]  oDsReset,
    output logic        oUnload,
    output logic        oUnloadSel,
    output logic [3:0]  oBestM,
    output logic        oFirReset,
    output logic        oFirCalc,
    output logic [1:0]  oError
`ifdef MODEL_SCHED_STATS_EN
    ,
    output logic [15:0] oBlockCount
`endif
);

    localparam logic [1:0] c_EMPTY  = 2'd0;
    localparam logic [1:0] c_LOADED = 2'd1;
    localparam logic [1:0] c_EVAL   = 2'd2;
    localparam logic [1:0] c_HELD   = 2'd3;

    localparam logic [1:0] c_U_IDLE   = 2'd0;
    localparam logic [1:0] c_U_UNLOAD = 2'd1;
    localparam logic [1:0] c_U_RUN    = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [3:0]       c_MAX_ORDER = 4'(MAX_ORDER);

    logic [1:0]       r_bank [2];
    logic [1:0]       w_bank_nxt [2];
    logic [3:0]       r_best [2];
    logic [3:0]       w_best_nxt [2];
    logic             r_lp, r_ep, r_up;
    logic             w_lp_nxt, w_ep_nxt, w_up_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_ustate, w_ustate_nxt;
    logic [1:0]       r_err, w_err_nxt;

    logic             w_load_ok, w_eval_ok, w_fb_ok, w_start, w_ds_ok, w_fir_ok;
    logic [3:0]       w_best_clamped;

    logic             r_ready, w_ready_nxt;
    logic [1:0]       r_fb_rst, w_fb_rst_nxt;
    logic [1:0]       r_ds_rst, w_ds_rst_nxt;
    logic             r_unload, w_unload_nxt;
    logic             r_unload_sel, w_unload_sel_nxt;
    logic [3:0]       r_best_m, w_best_m_nxt;
    logic             r_fir_rst, w_fir_rst_nxt;
    logic             r_fir_calc, w_fir_calc_nxt;

    // All qualifiers look at pre-update state so same-cycle events never see each other.
    assign w_load_ok      = iLoadDone && (r_bank[r_lp] == c_EMPTY);
    assign w_eval_ok      = iValid && ((r_bank[r_ep] == c_LOADED) || (r_bank[r_ep] == c_EVAL));
    assign w_fb_ok        = iFbDone && (r_bank[r_ep] == c_EVAL);
    assign w_start        = (r_ustate == c_U_IDLE) && (r_bank[r_up] == c_HELD);
    assign w_ds_ok        = (r_ustate == c_U_UNLOAD) && iDsDone;
    assign w_fir_ok       = (r_ustate == c_U_RUN) && iFirDone;
    assign w_best_clamped = (iBestM > c_MAX_ORDER) ? c_MAX_ORDER : iBestM;

    // State register (also holds the registered outputs)
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_bank[0]    <= c_EMPTY;
            r_bank[1]    <= c_EMPTY;
            r_best[0]    <= 4'd0;
            r_best[1]    <= 4'd0;
            r_lp         <= 1'b0;
            r_ep         <= 1'b0;
            r_up         <= 1'b0;
            r_cnt        <= '0;
            r_ustate     <= c_U_IDLE;
            r_err        <= 2'b00;
            r_ready      <= 1'b1;
            r_fb_rst     <= 2'b11;
            r_ds_rst     <= 2'b11;
            r_unload     <= 1'b0;
            r_unload_sel <= 1'b0;
            r_best_m     <= 4'd0;
            r_fir_rst    <= 1'b1;
            r_fir_calc   <= 1'b0;
        end else if (iEnable) begin
            r_bank[0]    <= w_bank_nxt[0];
            r_bank[1]    <= w_bank_nxt[1];
            r_best[0]    <= w_best_nxt[0];
            r_best[1]    <= w_best_nxt[1];
            r_lp         <= w_lp_nxt;
            r_ep         <= w_ep_nxt;
            r_up         <= w_up_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ustate     <= w_ustate_nxt;
            r_err        <= w_err_nxt;
            r_ready      <= w_ready_nxt;
            r_fb_rst     <= w_fb_rst_nxt;
            r_ds_rst     <= w_ds_rst_nxt;
            r_unload     <= w_unload_nxt;
            r_unload_sel <= w_unload_sel_nxt;
            r_best_m     <= w_best_m_nxt;
            r_fir_rst    <= w_fir_rst_nxt;
            r_fir_calc   <= w_fir_calc_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_bank_nxt[0] = r_bank[0];
        w_bank_nxt[1] = r_bank[1];
        w_best_nxt[0] = r_best[0];
        w_best_nxt[1] = r_best[1];
        w_lp_nxt      = r_lp;
        w_ep_nxt      = r_ep;
        w_up_nxt      = r_up;
        w_cnt_nxt     = r_cnt;
        w_ustate_nxt  = r_ustate;
        w_err_nxt     = r_err;

        if (w_load_ok) begin
            w_bank_nxt[r_lp] = c_LOADED;
            w_lp_nxt         = ~r_lp;
        end else if (iLoadDone) begin
            w_err_nxt[1] = 1'b1;
        end

        if (w_eval_ok) begin
            w_cnt_nxt = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            if (r_bank[r_ep] == c_LOADED) begin
                w_bank_nxt[r_ep] = c_EVAL;
            end
        end else if (iValid) begin
            w_err_nxt[0] = 1'b1;
        end

        if (w_fb_ok) begin
            w_best_nxt[r_ep] = w_best_clamped;
            w_bank_nxt[r_ep] = c_HELD;
            w_ep_nxt         = ~r_ep;
        end

        case (r_ustate)
            c_U_IDLE: begin
                if (w_start) begin
                    w_ustate_nxt = (r_best[r_up] != 4'd0) ? c_U_UNLOAD : c_U_RUN;
                end
            end
            c_U_UNLOAD: begin
                if (w_ds_ok) begin
                    w_ustate_nxt = c_U_RUN;
                end
            end
            c_U_RUN: begin
                if (w_fir_ok) begin
                    w_bank_nxt[r_up] = c_EMPTY;
                    w_up_nxt         = ~r_up;
                    w_ustate_nxt     = c_U_IDLE;
                end
            end
            default: w_ustate_nxt = c_U_IDLE;
        endcase
    end

    // Output logic (values registered on the next enabled edge)
    always_comb begin
        w_ready_nxt      = (w_bank_nxt[w_lp_nxt] == c_EMPTY);
        w_fb_rst_nxt     = 2'b00;
        w_ds_rst_nxt     = 2'b00;
        w_fir_rst_nxt    = w_start;
        w_unload_nxt     = (w_ustate_nxt == c_U_UNLOAD);
        w_fir_calc_nxt   = (w_ustate_nxt == c_U_RUN);
        w_unload_sel_nxt = r_unload_sel;
        w_best_m_nxt     = r_best_m;

        if (w_start) begin
            w_unload_sel_nxt = r_up;
            w_best_m_nxt     = r_best[r_up];
            if (r_best[r_up] == 4'd0) begin
                w_ds_rst_nxt[r_up] = 1'b1;
            end
        end
        if (w_ds_ok) begin
            w_ds_rst_nxt[r_up] = 1'b1;
            w_fb_rst_nxt[r_up] = 1'b1;
        end
    end

    assign oLoadSel   = r_lp;
    assign oEvalSel   = r_ep;
    assign oReady     = r_ready;
    assign oFbReset   = r_fb_rst;
    assign oDsReset   = r_ds_rst;
    assign oUnload    = r_unload;
    assign oUnloadSel = r_unload_sel;
    assign oBestM     = r_best_m;
    assign oFirReset  = r_fir_rst;
    assign oFirCalc   = r_fir_calc;
    assign oError     = r_err;

`ifdef MODEL_SCHED_STATS_EN
    logic [15:0] r_block_cnt;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_block_cnt <= 16'd0;
        end else if (iEnable && iFirDone && (r_block_cnt != 16'hFFFF)) begin
            r_block_cnt <= r_block_cnt + 16'd1;
        end
    end

    assign oBlockCount = r_block_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_model_bank_scheduler.sv
// ============================================================================
// Module   : tb_model_bank_scheduler
// Brief    : Directed self-checking bench for model_bank_scheduler (BLOCK_LEN=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_model_bank_scheduler;

    logic        iClock = 1'b0;
    logic        iReset, iEnable, iLoadDone, iValid, iFbDone, iDsDone, iFirDone;
    logic [3:0]  iBestM;
    logic        oLoadSel, oEvalSel, oReady, oUnload, oUnloadSel, oFirReset, oFirCalc;
    logic [1:0]  oFbReset, oDsReset, oError;
    logic [3:0]  oBestM;
`ifdef MODEL_SCHED_STATS_EN
    logic [15:0] oBlockCount;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    model_bank_scheduler #(.BLOCK_LEN(16), .MAX_ORDER(12), .CNT_W(4)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
        .iLoadDone(iLoadDone), .iValid(iValid), .iFbDone(iFbDone), .iBestM(iBestM),
        .iDsDone(iDsDone), .iFirDone(iFirDone),
        .oLoadSel(oLoadSel), .oEvalSel(oEvalSel), .oReady(oReady),
        .oFbReset(oFbReset), .oDsReset(oDsReset), .oUnload(oUnload),
        .oUnloadSel(oUnloadSel), .oBestM(oBestM), .oFirReset(oFirReset),
        .oFirCalc(oFirCalc), .oError(oError)
`ifdef MODEL_SCHED_STATS_EN
        , .oBlockCount(oBlockCount)
`endif
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        iReset = 1'b1; iEnable = 1'b1; iLoadDone = 1'b0; iValid = 1'b0;
        iFbDone = 1'b0; iBestM = 4'd0; iDsDone = 1'b0; iFirDone = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_fbreset", 16'(oFbReset), 16'h3);
        check("rst_dsreset", 16'(oDsReset), 16'h3);
        check("rst_firreset", 16'(oFirReset), 16'h1);
        check("rst_ready", 16'(oReady), 16'h1);
        check("rst_unload", 16'(oUnload), 16'h0);
        check("rst_firCalc", 16'(oFirCalc), 16'h0);
        check("rst_error", 16'(oError), 16'h0);
        check("rst_loadsel", 16'(oLoadSel), 16'h0);

        iReset = 1'b0;
        tick();
        check("rel_fbreset", 16'(oFbReset), 16'h0);
        check("rel_dsreset", 16'(oDsReset), 16'h0);
        check("rel_firreset", 16'(oFirReset), 16'h0);
        check("rel_ready", 16'(oReady), 16'h1);

        // Clock enable low freezes everything
        iEnable = 1'b0; iLoadDone = 1'b1;
        tick();
        check("freeze_loadsel", 16'(oLoadSel), 16'h0);
        iEnable = 1'b1;

        // Block 1 on bank 0, order 8
        tick(); iLoadDone = 1'b0;
        check("load0_loadsel", 16'(oLoadSel), 16'h1);
        check("load0_ready", 16'(oReady), 16'h1);
        iValid = 1'b1;
        repeat (16) tick();
        iValid = 1'b0;
        check("eval0_error", 16'(oError), 16'h0);
        iFbDone = 1'b1; iBestM = 4'd8;
        tick(); iFbDone = 1'b0;
        check("fb0_loadsel", 16'(oLoadSel), 16'h1);
        check("fb0_evalsel", 16'(oEvalSel), 16'h1);
        check("fb0_unload_early", 16'(oUnload), 16'h0);
        tick();
        check("u0_firreset", 16'(oFirReset), 16'h1);
        check("u0_unload", 16'(oUnload), 16'h1);
        check("u0_unloadsel", 16'(oUnloadSel), 16'h0);
        check("u0_bestm", 16'(oBestM), 16'h8);
        tick();
        check("u0_firreset_drop", 16'(oFirReset), 16'h0);
        check("u0_unload_hold", 16'(oUnload), 16'h1);
        iDsDone = 1'b1;
        tick(); iDsDone = 1'b0;
        check("ds0_unload", 16'(oUnload), 16'h0);
        check("ds0_dsreset", 16'(oDsReset), 16'h1);
        check("ds0_fbreset", 16'(oFbReset), 16'h1);
        check("ds0_fircalc", 16'(oFirCalc), 16'h1);

        // Load bank 1 while bank 0 runs FIRX
        iLoadDone = 1'b1;
        tick(); iLoadDone = 1'b0;
        check("run0_dsreset_drop", 16'(oDsReset), 16'h0);
        check("run0_bestm_hold", 16'(oBestM), 16'h8);
        check("load1_loadsel", 16'(oLoadSel), 16'h0);
        check("load1_ready", 16'(oReady), 16'h0);
        iFirDone = 1'b1;
        tick(); iFirDone = 1'b0;
        check("fir0_fircalc", 16'(oFirCalc), 16'h0);
        check("fir0_ready", 16'(oReady), 16'h1);

        // Block 2 on bank 1, order 15 clamps to 12
        iValid = 1'b1;
        repeat (3) tick();
        iValid = 1'b0;
        iFbDone = 1'b1; iBestM = 4'd15;
        tick(); iFbDone = 1'b0;
        check("fb1_evalsel", 16'(oEvalSel), 16'h0);
        tick();
        check("u1_unload", 16'(oUnload), 16'h1);
        check("u1_unloadsel", 16'(oUnloadSel), 16'h1);
        check("u1_bestm_clamp", 16'(oBestM), 16'hC);
        iDsDone = 1'b1;
        tick(); iDsDone = 1'b0;
        check("ds1_dsreset", 16'(oDsReset), 16'h2);
        check("ds1_fbreset", 16'(oFbReset), 16'h2);
        iFirDone = 1'b1;
        tick(); iFirDone = 1'b0;
        check("fir1_fircalc", 16'(oFirCalc), 16'h0);

        // Block 3 on bank 0, order 0 skips the unload
        iLoadDone = 1'b1;
        tick(); iLoadDone = 1'b0;
        iValid = 1'b1;
        tick(); iValid = 1'b0;
        iFbDone = 1'b1; iBestM = 4'd0;
        tick(); iFbDone = 1'b0;
        tick();
        check("z_firreset", 16'(oFirReset), 16'h1);
        check("z_unload", 16'(oUnload), 16'h0);
        check("z_dsreset", 16'(oDsReset), 16'h1);
        check("z_fbreset", 16'(oFbReset), 16'h0);
        check("z_fircalc", 16'(oFirCalc), 16'h1);
        check("z_bestm", 16'(oBestM), 16'h0);
        check("z_unloadsel", 16'(oUnloadSel), 16'h0);
        iFirDone = 1'b1;
        tick(); iFirDone = 1'b0;
        check("z_fircalc_drop", 16'(oFirCalc), 16'h0);
        check("z_error", 16'(oError), 16'h0);

        // Third load with both banks full is rejected
        iLoadDone = 1'b1;
        repeat (3) tick();
        iLoadDone = 1'b0;
        check("ovl_error", 16'(oError), 16'h2);
        check("ovl_loadsel", 16'(oLoadSel), 16'h1);
        check("ovl_ready", 16'(oReady), 16'h0);

        // Mid-operation reset aborts everything
        iReset = 1'b1;
        tick();
        check("mid_rst_loadsel", 16'(oLoadSel), 16'h0);
        check("mid_rst_error", 16'(oError), 16'h0);
        iReset = 1'b0;
        tick();

        // Sample with no evaluating bank
        iValid = 1'b1;
        tick(); iValid = 1'b0;
        check("novalid_error", 16'(oError), 16'h1);

        // Release of bank 0 and load of bank 0 in the same cycle
        iLoadDone = 1'b1;
        repeat (2) tick();
        iLoadDone = 1'b0;
        iValid = 1'b1;
        repeat (2) tick();
        iValid = 1'b0;
        iFbDone = 1'b1; iBestM = 4'd0;
        tick(); iFbDone = 1'b0;
        tick();
        check("sim_fircalc", 16'(oFirCalc), 16'h1);
        iFirDone = 1'b1; iLoadDone = 1'b1;
        tick(); iFirDone = 1'b0; iLoadDone = 1'b0;
        check("sim_error", 16'(oError), 16'h3);
        check("sim_loadsel", 16'(oLoadSel), 16'h0);
        check("sim_ready", 16'(oReady), 16'h1);
        iLoadDone = 1'b1;
        tick(); iLoadDone = 1'b0;
        check("reload_loadsel", 16'(oLoadSel), 16'h1);
        check("reload_ready", 16'(oReady), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
